lif_synapse_driver: RTL and testbench
=====================================

Name: lif_synapse_driver

Overview:
Synaptic current stage that sits directly upstream of each LIFNeuron. It converts a vector of presynaptic spikes, such as neighbouring neuron spike outputs or external inputs, into the 8-bit Isyn current the neuron integrates. Each spiking input adds a programmable signed weight. The current decays exponentially at a fixed tick rate and is clamped to the unsigned 8-bit range.

Parameters:
N_IN, 4, number of presynaptic spike inputs
W_W, 8, weight width (two's-complement signed)
DECAY_SHIFT, 3, decay amount per tick = isyn >> DECAY_SHIFT
DECAY_PERIOD, 4, clock cycles between decay ticks (>=1)
ACC_W, 12, internal signed sum width; must hold 255 + N_IN*2^(W_W-1) without overflow

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous assert, active-low
ena  input  1  stage enable; when low, the current and the decay timer freeze
spike_in  input  N_IN  presynaptic spikes, one bit per synapse, sampled every cycle
wr_en  input  1  weight write strobe
wr_addr  input  clog2(N_IN)  weight index
wr_data  input  W_W  signed weight value
isyn  output  8  synaptic current to the neuron Isyn input, registered
sat  output  1  one-cycle flag: the last update clamped at 0 or 255

Behaviour:
- Reset (async, rst_n=0):
  - isyn=0, sat=0, decay counter=0, spike_q=0.
  - All weights=0.
  - Reset mid-operation clears these immediately, without waiting for a clock edge.
- Input register: spike_q <= spike_in on every edge, regardless of ena.
- Decay timer:
  - The counter runs 0..DECAY_PERIOD-1 while ena=1, then wraps.
  - tick=1 in the cycle the counter equals DECAY_PERIOD-1.
  - DECAY_PERIOD=1 gives tick every cycle.
- Update on each edge with ena=1:
  - d = 0 if isyn==0; else max(1, isyn>>DECAY_SHIFT) if tick; else 0.
  - s = (isyn - d) + sum of weight[i] over all i with spike_q[i]=1. Sign-extend to ACC_W before summing.
  - isyn <= clamp(s, 0, 255).
  - sat <= (s<0) or (s>255).
- Ordering: decay is applied before the weights are added; clamping happens last.
- Latency: a spike_in bit high before edge k is captured into spike_q at edge k. Its weight appears on isyn after edge k+1, giving 2-cycle latency.
- ena=0:
  - isyn and the decay counter hold.
  - sat <= 0.
  - Spikes captured while ena=0 are lost; there is no pending-spike memory.
- Weight writes:
  - Take effect at the edge where wr_en=1, independent of ena.
  - An update at the same edge uses the old weight.
  - wr_addr >= N_IN is ignored.
- Simultaneous events: any number of spikes in the same cycle are summed in one update. Decay and spikes in the same cycle follow the ordering rule above.
- A held spike_in bit adds its weight on every cycle it is high (level-sensitive, not edge-detected).

Decomposition:
- Shared package lif_pkg: ISYN_W=8, the signed weight typedef, and a clamp-to-unsigned function. These are reused by LIFNeuron-side logic.
- One natural sub-module: lif_decay_timer (tick counter with enable). The weight register file and adder tree stay inline.

Test Plan:
1. Reset then idle: isyn=0 and sat=0 on every cycle. Assert rst_n low mid-run with isyn=120 -> isyn=0 immediately, before the next clock edge.
2. Write weight[0]=40, pulse spike_in[0] for one cycle (DECAY_PERIOD=4, DECAY_SHIFT=3) -> isyn=40 two edges later. It then steps 40->35->31->28 on successive ticks, 4 cycles apart.
3. Small-value decay: isyn=3 with no spikes -> 3->2->1->0 on successive ticks. It then holds at 0 and sat stays 0.
4. Excitatory saturation: weights[0..3]=100, hold all spikes -> isyn=255 with sat=1 on the first update. sat stays 1 while held, and isyn then decays normally after release.
5. Inhibition: isyn=50, weight[1]=-128, pulse spike_in[1] -> isyn=0 and sat=1 for one cycle. Simultaneous spike_in[0] (w=40) and spike_in[1] -> 50+40-128<0 -> isyn=0.
6. ena=0 for 10 cycles with isyn=60 and spikes toggling -> isyn holds at 60 and the counter is frozen. Writing weight[2]=7 during the freeze is visible on the first spike after ena returns. Writing wr_addr=4 changes nothing.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF synapse/neuron datapath.
// Holds the current width, the weight type and the unsigned clamp.
package lif_pkg;

    localparam int ISYN_W   = 8;
    localparam int ISYN_MAX = (1 << ISYN_W) - 1;
    localparam int WEIGHT_W = 8;

    typedef logic signed [WEIGHT_W-1:0] weight_t;

    // Callers sign-extend their accumulator to 32 bits before calling.
    function automatic logic [ISYN_W-1:0] clamp_u8(input logic signed [31:0] s);
        if (s < 0) begin
            return '0;
        end else if (s > ISYN_MAX) begin
            return '1;
        end else begin
            return s[ISYN_W-1:0];
        end
    endfunction

    function automatic logic is_clamped(input logic signed [31:0] s);
        return (s < 0) || (s > ISYN_MAX);
    endfunction

endpackage

// File: rtl/lif_decay_timer.sv
// Free-running decay tick generator: counts 0..PERIOD-1 while enabled.
// The tick is high for the whole cycle in which the count sits at PERIOD-1.
module lif_decay_timer #(
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(PERIOD - 1));
        cnt_d = cnt_q;
        if (ena) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lif_synapse_driver.sv
// Synaptic current stage: weighted spike sum with periodic exponential decay,
// clamped to the unsigned 8-bit Isyn range feeding a LIF neuron.
module lif_synapse_driver
    import lif_pkg::*;
#(
    parameter  int N_IN         = 4,
    parameter  int W_W          = WEIGHT_W,
    parameter  int DECAY_SHIFT  = 3,
    parameter  int DECAY_PERIOD = 4,
    parameter  int ACC_W        = 12,
    // wide enough to present index N_IN itself, so out-of-range writes are expressible
    localparam int ADDR_W       = $clog2(N_IN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [N_IN-1:0]   spike_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W_W-1:0]    wr_data,
    output logic [ISYN_W-1:0] isyn,
    output logic              sat
);

    logic tick;

    logic [N_IN-1:0]          spike_q;
    logic [N_IN-1:0]          spike_d;
    logic signed [W_W-1:0]    weight_q [N_IN];
    logic signed [W_W-1:0]    weight_d [N_IN];
    logic [ISYN_W-1:0]        isyn_q;
    logic [ISYN_W-1:0]        isyn_d;
    logic                     sat_q;
    logic                     sat_d;

    logic [ISYN_W-1:0]        decay_amt;
    logic signed [ACC_W-1:0]  sum;

    lif_decay_timer #(
        .PERIOD (DECAY_PERIOD)
    ) u_decay_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .tick  (tick)
    );

    always_comb begin
        spike_d = spike_in;

        weight_d = weight_q;
        if (wr_en) begin
            for (int i = 0; i < N_IN; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    weight_d[i] = wr_data;
                end
            end
        end

        // Shifted decay rounds to zero for small currents; force a step of 1
        // so the current always reaches 0 instead of sticking.
        decay_amt = '0;
        if (tick && (isyn_q != '0)) begin
            decay_amt = isyn_q >> DECAY_SHIFT;
            if (decay_amt == '0) begin
                decay_amt = ISYN_W'(1);
            end
        end

        sum = $signed({{(ACC_W-ISYN_W){1'b0}}, isyn_q})
            - $signed({{(ACC_W-ISYN_W){1'b0}}, decay_amt});
        for (int i = 0; i < N_IN; i++) begin
            if (spike_q[i]) begin
                sum = sum + ACC_W'(weight_q[i]);
            end
        end

        isyn_d = isyn_q;
        sat_d  = 1'b0;
        if (ena) begin
            isyn_d = clamp_u8(32'(sum));
            sat_d  = is_clamped(32'(sum));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q  <= '0;
            weight_q <= '{default: '0};
            isyn_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            spike_q  <= spike_d;
            weight_q <= weight_d;
            isyn_q   <= isyn_d;
            sat_q    <= sat_d;
        end
    end

    assign isyn = isyn_q;
    assign sat  = sat_q;

endmodule

// File: tb/tb_lif_synapse_driver.sv
// Directed bench for lif_synapse_driver with hand-computed per-edge expectations.
module tb_lif_synapse_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [3:0] spike_in = '0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] isyn;
    logic       sat;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] sv [$];
    logic       en [$];
    int         ei [$];
    int         es [$];

    lif_synapse_driver dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .spike_in (spike_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .isyn     (isyn),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 (or t=0); releases well before the next edge.
    task automatic do_reset(input string tag);
        rst_n    = 1'b0;
        ena      = 1'b0;
        spike_in = '0;
        wr_en    = 1'b0;
        #1;
        chk({tag, " isyn"}, int'(isyn), 0);
        chk({tag, " sat"}, int'(sat), 0);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic run_vec(input string tag);
        for (int i = 0; i < sv.size(); i++) begin
            spike_in = sv[i];
            ena      = en[i];
            @(posedge clk);
            #1;
            chk($sformatf("%s isyn e%0d", tag, i + 1), int'(isyn), ei[i]);
            chk($sformatf("%s sat e%0d", tag, i + 1), int'(sat), es[i]);
        end
        spike_in = '0;
        ena      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        #1;
        do_reset("por");

        // 1: idle after reset, then async reset from isyn=120
        sv = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        en = '{1, 1, 1, 1, 1};
        ei = '{0, 0, 0, 0, 0};
        es = '{0, 0, 0, 0, 0};
        run_vec("idle");
        do_reset("rst1");
        wr(3'd0, 8'd120);
        sv = '{4'h1, 4'h0};
        en = '{1, 1};
        ei = '{0, 120};
        es = '{0, 0};
        run_vec("load120");
        do_reset("midrun_rst");

        // 2: single pulse of w=40, then decay 40->35->31->28
        wr(3'd0, 8'd40);
        sv = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        en = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        ei = '{0, 40, 40, 35, 35, 35, 35, 31, 31, 31, 31, 28};
        es = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_vec("decay40");

        // 3: small value decays by at least 1 per tick and settles at 0
        do_reset("rst3");
        wr(3'd0, 8'd3);
        sv = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
               4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        en = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        ei = '{0, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        es = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_vec("decay3");

        // 4: excitatory saturation with all four synapses held
        do_reset("rst4");
        for (int i = 0; i < 4; i++) wr(3'(i), 8'd100);
        sv = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        en = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        ei = '{0, 255, 255, 255, 255, 255, 255, 224, 224, 224, 224, 196};
        es = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        run_vec("satpos");

        // 5: inhibition, alone and together with an excitatory spike
        do_reset("rst5");
        wr(3'd2, 8'd50);
        wr(3'd0, 8'd40);
        wr(3'd1, 8'h80);
        sv = '{4'h4, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h3, 4'h0, 4'h0};
        en = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        ei = '{0, 50, 50, 0, 0, 50, 50, 0, 0};
        es = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        run_vec("inhib");

        // 6: freeze with ena=0, writes during the freeze, resume
        do_reset("rst6");
        wr(3'd0, 8'd60);
        sv = '{4'h1, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
        en = '{1, 1, 0, 0, 0, 0};
        ei = '{0, 60, 60, 60, 60, 60};
        es = '{0, 0, 0, 0, 0, 0};
        run_vec("freezeA");
        wr(3'd2, 8'd7);
        chk("freeze wr2 isyn", int'(isyn), 60);
        chk("freeze wr2 sat", int'(sat), 0);
        wr(3'd4, 8'd99);
        chk("freeze wr4 isyn", int'(isyn), 60);
        sv = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h4, 4'h1, 4'h0, 4'h0, 4'h0};
        en = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        ei = '{60, 60, 60, 60, 60, 53, 60, 120, 120, 105};
        es = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_vec("freezeB");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
